// File: rtl/cordic_gain_comp_if.sv
// Handshake and result bus between rotational_cordic, the gain compensator and its consumer.
interface cordic_gain_comp_if;
   logic        data_out_rot;
   logic [15:0] xprime;
   logic [15:0] yprime;
   logic [15:0] x_scaled;
   logic [15:0] y_scaled;
   logic        scaled_valid;
   logic        busy;
   logic        overrun;

   modport master (
      output data_out_rot, xprime, yprime,
      input  x_scaled, y_scaled, scaled_valid, busy, overrun
   );

   modport slave (
      input  data_out_rot, xprime, yprime,
      output x_scaled, y_scaled, scaled_valid, busy, overrun
   );
endinterface

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain: bit-serial shift-add multiply of both components by K (Q0.16),
// rounded half-up, 16 cycles per vector, result presented with a one-cycle valid strobe.
//
// state | meaning
// IDLE  | waiting for a CORDIC completion strobe
// MUL   | 16 shift-add cycles, one K bit per cycle, LSB first
// DONE  | results registered, scaled_valid high; a strobe here restarts immediately
module cordic_gain_comp #(
   parameter logic [15:0] K_CONST = 16'h9B75
) (
   input  logic             clk,
   input  logic             reset,
   cordic_gain_comp_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic signed [32:0] ROUND_HALF = 33'sd32768;

   logic [1:0]         state;
   logic [3:0]         cnt;
   logic [15:0]        x_op;
   logic [15:0]        y_op;
   logic signed [32:0] x_acc;
   logic signed [32:0] y_acc;
   logic [15:0]        x_scaled_q;
   logic [15:0]        y_scaled_q;
   logic               scaled_valid_q;
   logic               overrun_q;

   logic signed [32:0] x_ext;
   logic signed [32:0] y_ext;
   logic signed [32:0] x_term;
   logic signed [32:0] y_term;
   logic signed [32:0] x_sum;
   logic signed [32:0] y_sum;
   logic signed [32:0] x_rnd;
   logic signed [32:0] y_rnd;
   logic               unused_rnd_bits;

   always_comb begin
      x_ext  = {{17{x_op[15]}}, x_op};
      y_ext  = {{17{y_op[15]}}, y_op};
      x_term = K_CONST[cnt] ? (x_ext <<< cnt) : 33'sd0;
      y_term = K_CONST[cnt] ? (y_ext <<< cnt) : 33'sd0;
      x_sum  = x_acc + x_term;
      y_sum  = y_acc + y_term;
      x_rnd  = x_sum + ROUND_HALF;
      y_rnd  = y_sum + ROUND_HALF;
   end

   // |op*K| < 2^31, so bits [31:16] are exactly the arithmetic >>>16 truncated to 16 bits.
   assign unused_rnd_bits = ^{x_rnd[32], x_rnd[15:0], y_rnd[32], y_rnd[15:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         cnt            <= 4'd0;
         x_op           <= 16'd0;
         y_op           <= 16'd0;
         x_acc          <= 33'sd0;
         y_acc          <= 33'sd0;
         x_scaled_q     <= 16'd0;
         y_scaled_q     <= 16'd0;
         scaled_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         scaled_valid_q <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.data_out_rot) begin
                  x_op  <= bus.xprime;
                  y_op  <= bus.yprime;
                  x_acc <= 33'sd0;
                  y_acc <= 33'sd0;
                  cnt   <= 4'd0;
                  state <= ST_MUL;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               x_acc <= x_sum;
               y_acc <= y_sum;
               if (bus.data_out_rot) begin
                  overrun_q <= 1'b1;
               end
               if (cnt == 4'd15) begin
                  x_scaled_q     <= x_rnd[31:16];
                  y_scaled_q     <= y_rnd[31:16];
                  scaled_valid_q <= 1'b1;
                  state          <= ST_DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.x_scaled     = x_scaled_q;
   assign bus.y_scaled     = y_scaled_q;
   assign bus.scaled_valid = scaled_valid_q;
   assign bus.busy         = (state == ST_MUL);
   assign bus.overrun      = overrun_q;

endmodule
